// File: rtl/aes_pkg.sv
// Shared definitions for the AES round demultiplexer: FSM encoding, legal
// round counts and round counter width.
package aes_pkg;

   localparam int CNT_W = 4;

   // Rounds per block for AES-128, AES-192 and AES-256.
   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/aes_round_ctr.sv
// Round counter for the AES round demultiplexer: load to 1, clear to 0,
// saturating increment, terminal-count flag when the count reaches NR.
module aes_round_ctr
   import aes_pkg::*;
#(
   parameter int NR = NR_AES128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NR);

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(1);
      end else if (inc && !tc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == CNT_LAST);

endmodule

// File: rtl/aes_round_demux.sv
// Routes each round result either back to the round-input select (fb_*) or,
// after the last round, to the output holding register (out_*).
// Optional sticky protocol error flag: define AES_ROUND_DEMUX_ERR_EN.
module aes_round_demux
   import aes_pkg::*;
#(
   parameter int N  = 128,
   parameter int NR = NR_AES128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     In,
   input  logic             in_valid,
   output logic [N-1:0]     fb_data,
   output logic             fb_valid,
   output logic [N-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] round_cnt,
   output logic             busy
`ifdef AES_ROUND_DEMUX_ERR_EN
   ,
   output logic             err
`endif
);

   state_t state;
   logic   ctr_load;
   logic   ctr_clear;
   logic   ctr_inc;
   logic   last_round;
   logic   start_ok;
   logic   handshake;

   assign start_ok  = (state == ST_IDLE) && start;
   assign handshake = (state == ST_HOLD) && out_valid && out_ready;
   assign ctr_load  = start_ok;
   assign ctr_clear = handshake;
   assign ctr_inc   = (state == ST_RUN) && in_valid && !last_round;

   aes_round_ctr #(
      .NR (NR)
   ) u_round_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ctr_load),
      .clear (ctr_clear),
      .inc   (ctr_inc),
      .cnt   (round_cnt),
      .tc    (last_round)
   );

   // NOTE: the data registers are reset as well as the control flops, so an
   // abandoned block leaves no stale word visible on fb_data or out_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         fb_data   <= '0;
         fb_valid  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         fb_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (in_valid) begin
                  if (!last_round) begin
                     fb_data  <= In;
                     fb_valid <= 1'b1;
                  end else begin
                     out_data  <= In;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // start is deliberately not looked at here, even alongside the handshake
               if (handshake) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

`ifdef AES_ROUND_DEMUX_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (start_ok) begin
         err <= 1'b0;
      end else if (in_valid && (state != ST_RUN)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_round_demux.sv
// Self-checking bench for aes_round_demux: NR=10 and NR=14 instances share one
// stimulus stream and are compared every cycle against a block-level model.
module tb_aes_round_demux;

   localparam int N = 128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [N-1:0] din = '0;

   logic [N-1:0] fb_data_o  [2];
   logic         fb_valid_o [2];
   logic [N-1:0] out_data_o [2];
   logic         out_valid_o[2];
   logic [3:0]   round_cnt_o[2];
   logic         busy_o     [2];
`ifdef AES_ROUND_DEMUX_ERR_EN
   logic         err_o      [2];
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int fb_cnt   = 0;

   always #5 clk = ~clk;

   aes_round_demux #(.N(N), .NR(10)) dut10 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .In        (din),
      .in_valid  (in_valid),
      .fb_data   (fb_data_o[0]),
      .fb_valid  (fb_valid_o[0]),
      .out_data  (out_data_o[0]),
      .out_valid (out_valid_o[0]),
      .out_ready (out_ready),
      .round_cnt (round_cnt_o[0]),
      .busy      (busy_o[0])
`ifdef AES_ROUND_DEMUX_ERR_EN
      ,
      .err       (err_o[0])
`endif
   );

   aes_round_demux #(.N(N), .NR(14)) dut14 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .In        (din),
      .in_valid  (in_valid),
      .fb_data   (fb_data_o[1]),
      .fb_valid  (fb_valid_o[1]),
      .out_data  (out_data_o[1]),
      .out_valid (out_valid_o[1]),
      .out_ready (out_ready),
      .round_cnt (round_cnt_o[1]),
      .busy      (busy_o[1])
`ifdef AES_ROUND_DEMUX_ERR_EN
      ,
      .err       (err_o[1])
`endif
   );

   // Block-level view: is a block open, has its final round arrived, how many
   // rounds have been accepted, and the last words routed each way.
   typedef struct {
      bit           open;
      bit           done;
      int           rounds;
      logic [N-1:0] fb;
      bit           fbv;
      logic [N-1:0] out;
      bit           outv;
      bit           err;
   } model_t;

   model_t m[2];
   int     nr_of[2] = '{10, 14};

   function automatic logic [N-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m[i].open   = 1'b0;
         m[i].done   = 1'b0;
         m[i].rounds = 0;
         m[i].fb     = '0;
         m[i].fbv    = 1'b0;
         m[i].out    = '0;
         m[i].outv   = 1'b0;
         m[i].err    = 1'b0;
      end
   endtask

   task automatic model_step(input bit st, input bit iv, input bit ordy, input logic [N-1:0] d);
      for (int i = 0; i < 2; i++) begin
         m[i].fbv = 1'b0;
         if (!m[i].open) begin
            if (st) begin
               m[i].open   = 1'b1;
               m[i].rounds = 1;
               m[i].err    = 1'b0;
            end else if (iv) begin
               m[i].err = 1'b1;
            end
         end else if (m[i].done) begin
            if (iv) m[i].err = 1'b1;
            if (ordy) begin
               m[i].open   = 1'b0;
               m[i].done   = 1'b0;
               m[i].rounds = 0;
               m[i].outv   = 1'b0;
            end
         end else if (iv) begin
            if (m[i].rounds < nr_of[i]) begin
               m[i].fb     = d;
               m[i].fbv    = 1'b1;
               m[i].rounds = m[i].rounds + 1;
            end else begin
               m[i].out  = d;
               m[i].outv = 1'b1;
               m[i].done = 1'b1;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("nr%0d fb_valid", nr_of[i]), N'(fb_valid_o[i]), N'(m[i].fbv));
         check($sformatf("nr%0d fb_data", nr_of[i]), fb_data_o[i], m[i].fb);
         check($sformatf("nr%0d out_valid", nr_of[i]), N'(out_valid_o[i]), N'(m[i].outv));
         check($sformatf("nr%0d out_data", nr_of[i]), out_data_o[i], m[i].out);
         check($sformatf("nr%0d round_cnt", nr_of[i]), N'(round_cnt_o[i]), N'(m[i].rounds));
         check($sformatf("nr%0d busy", nr_of[i]), N'(busy_o[i]), N'(m[i].open));
`ifdef AES_ROUND_DEMUX_ERR_EN
         check($sformatf("nr%0d err", nr_of[i]), N'(err_o[i]), N'(m[i].err));
`endif
      end
   endtask

   // Apply one cycle of inputs, let the edge happen, then compare just after it.
   task automatic cycle(input bit st, input bit iv, input bit ordy, input logic [N-1:0] d);
      start     = st;
      in_valid  = iv;
      out_ready = ordy;
      din       = d;
      @(posedge clk);
      model_step(st, iv, ordy, d);
      #1;
      check_all();
      if (fb_valid_o[0]) fb_cnt++;
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      start    = 1'b0;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // in_valid with no block open is ignored
      cycle(1'b0, 1'b1, 1'b1, rnd_word());

      // NR=10 block with In equal to the round index, consumer always ready
      fb_cnt = 0;
      cycle(1'b1, 1'b0, 1'b1, '0);
      for (int r = 1; r <= 10; r++) cycle(1'b0, 1'b1, 1'b1, N'(r));
      repeat (3) cycle(1'b0, 1'b0, 1'b1, '0);
      check("nr10 fb strobe count", N'(fb_cnt), N'(9));

      // NR=14 block with a stalled consumer; NR=10 reaches HOLD early and
      // sees its late rounds dropped
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int r = 1; r <= 14; r++) cycle(1'b0, 1'b1, 1'b0, rnd_word());
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, rnd_word());
      repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("nr14 idle after handshake", N'(busy_o[1]), N'(0));
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);

      // start during RUN at round 4 is ignored; counting carries on
      cycle(1'b1, 1'b0, 1'b1, '0);
      for (int r = 1; r <= 3; r++) cycle(1'b0, 1'b1, 1'b1, rnd_word());
      cycle(1'b1, 1'b1, 1'b1, rnd_word());
      check("nr10 no restart", N'(round_cnt_o[0]), N'(5));
      cycle(1'b1, 1'b0, 1'b1, '0);

      // reset mid-block at round 6, then rounds without start produce nothing
      cycle(1'b0, 1'b1, 1'b1, rnd_word());
      do_reset();
      for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 1'b1, rnd_word());

      // HOLD handshake coinciding with start returns to IDLE
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int r = 1; r <= 10; r++) cycle(1'b0, 1'b1, 1'b0, rnd_word());
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b1, '0);
      check("nr10 cnt after hold+start", N'(round_cnt_o[0]), N'(0));
      check("nr10 busy after hold+start", N'(busy_o[0]), N'(0));
      cycle(1'b0, 1'b0, 1'b1, '0);

      // randomized traffic, with one asynchronous reset in the middle
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if (k == 200) do_reset();
         cycle(($urandom_range(7) == 0), $urandom_range(1) == 1,
               ($urandom_range(3) != 0), rnd_word());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
